// File: rtl/spectrum_frame_engine.sv
// ---------------------------------------------------------------------------
// spectrum_frame_engine : per-frame FFT sequencer and bar/peak reducer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spectrum_frame_engine #(
  parameter int N        = 256,
  parameter int WIDTH    = 18,
  parameter int NUM_BARS = 32,
  parameter int BAR_MAX  = 480,
  parameter int SHIFT    = 6,
  parameter int DECAY    = 2,
  parameter int TIMEOUT  = 4096,
  parameter int HW       = $clog2(BAR_MAX + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_frame_tick,
  input  logic                           i_mode,
  input  logic                           i_peak_en,
  input  logic                           i_fft_done,
  input  logic [0:N-1][WIDTH:0]          i_freq_mag,
  output logic                           o_fft_start,
  output logic [0:NUM_BARS-1][HW-1:0]    o_bars,
  output logic [0:NUM_BARS-1][HW-1:0]    o_peaks,
  output logic                           o_bars_valid,
  output logic                           o_busy,
  output logic                           o_overrun,
  output logic                           o_timeout_err
);

  localparam int BPB  = N / 2 / NUM_BARS;
  localparam int LBPB = $clog2(BPB);
  localparam int ACCW = WIDTH + 1 + LBPB;
  localparam int BINW = $clog2(N / 2);
  localparam int KW   = $clog2(N);
  localparam int BW   = $clog2(NUM_BARS);
  localparam int WDW  = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_REDUCE  = 3'd2;
  localparam logic [2:0] S_PEAK    = 3'd3;
  localparam logic [2:0] S_PUBLISH = 3'd4;

  logic [2:0]                        r_state;
  logic                              r_fft_start;
  logic                              r_valid;
  logic                              r_overrun;
  logic                              r_timeout;
  logic                              r_mode;
  logic                              r_peak_en;
  logic [WDW-1:0]                    r_wdog;
  logic [BINW-1:0]                   r_bin;
  logic [BW-1:0]                     r_pk;
  logic [ACCW-1:0]                   r_acc;
  logic [0:NUM_BARS-1][HW-1:0]       r_next_bar;
  logic [0:NUM_BARS-1][HW-1:0]       r_next_peak;
  logic [0:NUM_BARS-1][HW-1:0]       r_bars;
  logic [0:NUM_BARS-1][HW-1:0]       r_peaks;

  logic [WIDTH:0]                    w_mag;
  logic [ACCW-1:0]                   w_mag_ext;
  logic [ACCW-1:0]                   w_acc_next;
  logic [ACCW-1:0]                   w_shifted;
  logic [HW-1:0]                     w_clamped;
  logic                              w_grp_last;
  logic [BW-1:0]                     w_bar_idx;
  logic [HW-1:0]                     w_nb;
  logic [HW-1:0]                     w_old;
  logic [HW-1:0]                     w_peak_new;

  // DC bin never contributes to the lowest bar
  assign w_mag      = (r_bin == '0) ? '0 : i_freq_mag[KW'(r_bin)];
  assign w_mag_ext  = ACCW'(w_mag);
  assign w_acc_next = r_mode ? ((w_mag_ext > r_acc) ? w_mag_ext : r_acc)
                             : (r_acc + w_mag_ext);
  assign w_shifted  = w_acc_next >> SHIFT;
  assign w_clamped  = (w_shifted > ACCW'(BAR_MAX)) ? HW'(BAR_MAX) : w_shifted[HW-1:0];
  assign w_grp_last = (r_bin & BINW'(BPB - 1)) == BINW'(BPB - 1);
  assign w_bar_idx  = BW'(r_bin >> LBPB);

  // Peaks are compared against the currently published peak markers
  assign w_nb  = r_next_bar[r_pk];
  assign w_old = r_peaks[r_pk];

  always_comb begin
    w_peak_new = w_nb;
    if (r_peak_en && (w_nb < w_old)) begin
      w_peak_new = (w_old >= HW'(DECAY)) ? (w_old - HW'(DECAY)) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_fft_start <= 1'b0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
      r_mode      <= 1'b0;
      r_peak_en   <= 1'b0;
      r_wdog      <= '0;
      r_bin       <= '0;
      r_pk        <= '0;
      r_acc       <= '0;
      r_next_bar  <= '0;
      r_next_peak <= '0;
      r_bars      <= '0;
      r_peaks     <= '0;
    end else begin
      r_fft_start <= 1'b0;
      r_valid     <= 1'b0;
      if (i_frame_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_frame_tick) begin
            r_state     <= S_WAIT;
            r_fft_start <= 1'b1;
            r_wdog      <= '0;
          end
        end
        S_WAIT: begin
          if (i_fft_done) begin
            r_state   <= S_REDUCE;
            r_mode    <= i_mode;
            r_peak_en <= i_peak_en;
            r_bin     <= '0;
            r_acc     <= '0;
          end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_REDUCE: begin
          if (w_grp_last) begin
            r_next_bar[w_bar_idx] <= w_clamped;
            r_acc                 <= '0;
          end else begin
            r_acc <= w_acc_next;
          end
          r_bin <= r_bin + 1'b1;
          if (r_bin == BINW'(N / 2 - 1)) begin
            r_state <= S_PEAK;
            r_pk    <= '0;
          end
        end
        S_PEAK: begin
          r_next_peak[r_pk] <= w_peak_new;
          r_pk              <= r_pk + 1'b1;
          // Publish on entry to PUBLISH so data and strobe appear together
          if (r_pk == BW'(NUM_BARS - 1)) begin
            r_state <= S_PUBLISH;
            r_valid <= 1'b1;
            r_bars  <= r_next_bar;
            for (int i = 0; i < NUM_BARS; i++) begin
              r_peaks[i] <= (BW'(i) == r_pk) ? w_peak_new : r_next_peak[i];
            end
          end
        end
        S_PUBLISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_fft_start   = r_fft_start;
  assign o_bars        = r_bars;
  assign o_peaks       = r_peaks;
  assign o_bars_valid  = r_valid;
  assign o_busy        = (r_state != S_IDLE);
  assign o_overrun     = r_overrun;
  assign o_timeout_err = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_spectrum_frame_engine.sv
// ---------------------------------------------------------------------------
// tb_spectrum_frame_engine : randomized self-checking bench with frame model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spectrum_frame_engine;

  localparam int N       = 256;
  localparam int WIDTH   = 18;
  localparam int NB      = 32;
  localparam int BAR_MAX = 480;
  localparam int SHIFT   = 6;
  localparam int DECAY   = 2;
  localparam int TIMEOUT = 4096;
  localparam int HW      = 9;
  localparam int MW      = WIDTH + 1;
  localparam int BPB     = N / 2 / NB;

  logic                     clk;
  logic                     rst;
  logic                     i_frame_tick;
  logic                     i_mode;
  logic                     i_peak_en;
  logic                     i_fft_done;
  logic [0:N-1][WIDTH:0]    i_freq_mag;
  logic                     o_fft_start;
  logic [0:NB-1][HW-1:0]    o_bars;
  logic [0:NB-1][HW-1:0]    o_peaks;
  logic                     o_bars_valid;
  logic                     o_busy;
  logic                     o_overrun;
  logic                     o_timeout_err;

  int tests_run;
  int tests_failed;
  int mag[N];
  int m_bar[NB];
  int m_peak[NB];

  spectrum_frame_engine dut (
    .clk          (clk),
    .rst          (rst),
    .i_frame_tick (i_frame_tick),
    .i_mode       (i_mode),
    .i_peak_en    (i_peak_en),
    .i_fft_done   (i_fft_done),
    .i_freq_mag   (i_freq_mag),
    .o_fft_start  (o_fft_start),
    .o_bars       (o_bars),
    .o_peaks      (o_peaks),
    .o_bars_valid (o_bars_valid),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun),
    .o_timeout_err(o_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_mags();
    for (int k = 0; k < N; k++) i_freq_mag[k] = MW'(mag[k]);
  endtask

  task automatic fill_const(input int v);
    for (int k = 0; k < N; k++) mag[k] = v;
    load_mags();
  endtask

  task automatic fill_random();
    int sel;
    int mask;
    sel  = $urandom_range(0, 2);
    mask = (sel == 0) ? 32'h3FF : ((sel == 1) ? 32'h3FFF : 32'h7FFFF);
    for (int k = 0; k < N; k++) mag[k] = int'($urandom) & mask;
    load_mags();
  endtask

  // Reference: group usable bins, reduce, scale, clamp, then apply peak rule
  task automatic model_frame(input bit mode, input bit pen);
    longint acc;
    longint v;
    longint s;
    int     bar;
    for (int b = 0; b < NB; b++) begin
      acc = 0;
      for (int j = 0; j < BPB; j++) begin
        v = (b * BPB + j == 0) ? 0 : longint'(mag[b * BPB + j]);
        if (mode) acc = (v > acc) ? v : acc;
        else      acc = acc + v;
      end
      s   = acc >>> SHIFT;
      bar = (s > BAR_MAX) ? BAR_MAX : int'(s);
      if (!pen || bar >= m_peak[b]) m_peak[b] = bar;
      else m_peak[b] = (m_peak[b] > DECAY) ? m_peak[b] - DECAY : 0;
      m_bar[b] = bar;
    end
  endtask

  task automatic check_outputs(input string pfx);
    for (int b = 0; b < NB; b++) begin
      check($sformatf("%s_bar[%0d]", pfx, b), o_bars[b], m_bar[b]);
      check($sformatf("%s_peak[%0d]", pfx, b), o_peaks[b], m_peak[b]);
    end
  endtask

  task automatic run_frame(input string pfx, input bit mode, input bit pen, input bit toggle);
    int n;
    int extra_starts;
    bit got;
    i_mode       = mode;
    i_peak_en    = pen;
    i_frame_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_frame_tick = 1'b0;
    check({pfx, "_start"}, o_fft_start, 1);
    extra_starts = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      extra_starts += int'(o_fft_start);
    end
    i_fft_done = 1'b1;
    n   = 0;
    got = 1'b0;
    while (n < 400 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      i_fft_done = 1'b0;
      if (toggle && n == 40) begin
        i_mode    = ~i_mode;
        i_peak_en = ~i_peak_en;
      end
      extra_starts += int'(o_fft_start);
      if (o_bars_valid) got = 1'b1;
    end
    check({pfx, "_single_start"}, extra_starts, 0);
    check({pfx, "_latency"}, n, 161);
    model_frame(mode, pen);
    check_outputs(pfx);
    @(posedge clk);
    @(negedge clk);
    check({pfx, "_valid_pulse"}, o_bars_valid, 0);
    check({pfx, "_idle"}, o_busy, 0);
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_bar[b]  = 0;
      m_peak[b] = 0;
    end
  endtask

  initial begin
    int n;
    int cnt;
    int starts;
    int valids;
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    i_frame_tick = 1'b0;
    i_mode       = 1'b0;
    i_peak_en    = 1'b0;
    i_fft_done   = 1'b0;
    fill_const(0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_start", o_fft_start, 0);
    check("rst_valid", o_bars_valid, 0);
    check("rst_flags", {o_overrun, o_timeout_err}, 0);
    check_outputs("rst");
    rst = 1'b0;
    @(negedge clk);

    // Sum, all bins 256
    fill_const(256);
    run_frame("sum", 1'b0, 1'b0, 1'b0);
    check("sum_bar0", o_bars[0], 12);
    check("sum_bar31", o_bars[31], 16);

    // Max with mid-reduce mode toggle
    run_frame("max", 1'b1, 1'b0, 1'b1);
    check("max_bar0", o_bars[0], 4);
    check("max_bar17", o_bars[17], 4);

    // Clamp
    fill_const(1 << 18);
    run_frame("clamp", 1'b0, 1'b0, 1'b0);
    check("clamp_bar5", o_bars[5], BAR_MAX);

    // Peak hold then decay, then tracking
    fill_const(6400);
    run_frame("pkA", 1'b1, 1'b0, 1'b0);
    check("pkA_bar3", o_bars[3], 100);
    fill_const(0);
    run_frame("pkB", 1'b0, 1'b1, 1'b0);
    check("pkB_peak3", o_peaks[3], 98);
    check("pkB_bar3", o_bars[3], 0);
    run_frame("pkC", 1'b0, 1'b0, 1'b0);
    check("pkC_peak3", o_peaks[3], 0);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      fill_random();
      run_frame($sformatf("rnd%0d", f), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    check("no_overrun_yet", o_overrun, 0);
    check("no_timeout_yet", o_timeout_err, 0);

    // Watchdog expiry with an overlapping frame tick
    fill_random();
    i_frame_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_frame_tick = 1'b0;
    cnt    = int'(o_busy);
    starts = int'(o_fft_start);
    valids = 0;
    n      = 0;
    while (o_busy && n < 5000) begin
      i_frame_tick = (n == 20);
      @(posedge clk);
      @(negedge clk);
      i_frame_tick = 1'b0;
      n++;
      cnt    += int'(o_busy);
      starts += int'(o_fft_start);
      valids += int'(o_bars_valid);
    end
    check("wd_cycles", cnt, TIMEOUT);
    check("wd_timeout_err", o_timeout_err, 1);
    check("wd_overrun", o_overrun, 1);
    check("wd_starts", starts, 1);
    check("wd_no_valid", valids, 0);
    check_outputs("wd");

    // Asynchronous reset in the middle of REDUCE
    fill_random();
    i_frame_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    i_fft_done = 1'b1;
    @(negedge clk);
    i_fft_done = 1'b0;
    repeat (30) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_flags", {o_overrun, o_timeout_err, o_bars_valid, o_fft_start}, 0);
    model_reset();
    check_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_random();
    run_frame("post_rst", 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
